// File: rtl/ok_frame_rx.sv
// Consumer end of the 7-bit "OK" status link: recognises "O","K",CR, holds a detect event until acked,
// and keeps saturating frame/error counters. Define OK_FRAME_RX_CASE_EN to also accept lower-case 'o'/'k'.
module ok_frame_rx #(
   parameter int CNT_W       = 8,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   input  logic [6:0]       i_data,
   output logic             o_ready,
   output logic             o_ok_valid,
   input  logic             i_ok_ack,
   output logic [CNT_W-1:0] o_ok_count,
   output logic [CNT_W-1:0] o_err_count,
   output logic [1:0]       o_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_O    = 2'd1,
      S_K    = 2'd2
   } state_t;

   localparam int                   TIMER_W    = $clog2(TIMEOUT_CYC);
   localparam logic [TIMER_W-1:0]   TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);

   state_t             state_q, state_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic               ok_valid_q;
   logic [CNT_W-1:0]   ok_cnt_q, err_cnt_q;
   logic               xfer, ok_set, err_inc;

   function automatic logic is_o(input logic [6:0] c);
`ifdef OK_FRAME_RX_CASE_EN
      return (c == 7'h4F) || (c == 7'h6F);
`else
      return c == 7'h4F;
`endif
   endfunction

   function automatic logic is_k(input logic [6:0] c);
`ifdef OK_FRAME_RX_CASE_EN
      return (c == 7'h4B) || (c == 7'h6B);
`else
      return c == 7'h4B;
`endif
   endfunction

   // Stall only the CR slot while an earlier event is still unacknowledged.
   assign o_ready     = !((state_q == S_K) && ok_valid_q && !i_ok_ack);
   assign xfer        = i_valid && o_ready;
   assign o_ok_valid  = ok_valid_q;
   assign o_ok_count  = ok_cnt_q;
   assign o_err_count = err_cnt_q;
   assign o_state     = state_q;

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      ok_set  = 1'b0;
      err_inc = 1'b0;
      case (state_q)
         S_IDLE: begin
            timer_d = '0;
            if (xfer && is_o(i_data)) state_d = S_O;
         end
         S_O: begin
            if (xfer) begin
               timer_d = '0;
               if (is_k(i_data)) begin
                  state_d = S_K;
               end else if (is_o(i_data)) begin
                  err_inc = 1'b1;
               end else begin
                  state_d = S_IDLE;
                  err_inc = 1'b1;
               end
            end else if (timer_q == TIMER_LAST) begin
               state_d = S_IDLE;
               timer_d = '0;
               err_inc = 1'b1;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         S_K: begin
            if (xfer) begin
               timer_d = '0;
               if (i_data == 7'h0D) begin
                  state_d = S_IDLE;
                  ok_set  = 1'b1;
               end else if (is_o(i_data)) begin
                  state_d = S_O;
                  err_inc = 1'b1;
               end else begin
                  state_d = S_IDLE;
                  err_inc = 1'b1;
               end
            end else if (!o_ready) begin
               timer_d = timer_q;
            end else if (timer_q == TIMER_LAST) begin
               state_d = S_IDLE;
               timer_d = '0;
               err_inc = 1'b1;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            timer_d = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
      end
   end

   // A new event in the same cycle as an ack stays pending.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)      ok_valid_q <= 1'b0;
      else if (ok_set)   ok_valid_q <= 1'b1;
      else if (i_ok_ack) ok_valid_q <= 1'b0;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ok_cnt_q  <= '0;
         err_cnt_q <= '0;
      end else begin
         if (ok_set && (ok_cnt_q != '1))   ok_cnt_q  <= ok_cnt_q + 1'b1;
         if (err_inc && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + 1'b1;
      end
   end

endmodule

// File: tb/tb_ok_frame_rx.sv
// Bench for ok_frame_rx: cycle-by-cycle reference model plus directed literal checks.
// Honours OK_FRAME_RX_CASE_EN the same way the design does.
module tb_ok_frame_rx;

   localparam int TMO = 64;

   logic       i_clk   = 1'b0;
   logic       i_rst_n = 1'b0;
   logic       i_valid = 1'b0;
   logic [6:0] i_data  = '0;
   logic       i_ok_ack = 1'b0;

   logic       o_ready, o_ok_valid, r2_ready, r2_ok_valid;
   logic [7:0] o_ok_count, o_err_count;
   logic [1:0] r2_ok_count, r2_err_count;
   logic [1:0] o_state, r2_state;

   int checks   = 0;
   int failures = 0;

   ok_frame_rx #(.CNT_W(8), .TIMEOUT_CYC(TMO)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_data(i_data),
      .o_ready(o_ready), .o_ok_valid(o_ok_valid), .i_ok_ack(i_ok_ack),
      .o_ok_count(o_ok_count), .o_err_count(o_err_count), .o_state(o_state));

   ok_frame_rx #(.CNT_W(2), .TIMEOUT_CYC(TMO)) dut2 (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_data(i_data),
      .o_ready(r2_ready), .o_ok_valid(r2_ok_valid), .i_ok_ack(i_ok_ack),
      .o_ok_count(r2_ok_count), .o_err_count(r2_err_count), .o_state(r2_state));

   always #5 i_clk = ~i_clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit is_o(input logic [6:0] c);
`ifdef OK_FRAME_RX_CASE_EN
      return (c == 7'h4F) || (c == 7'h6F);
`else
      return c == 7'h4F;
`endif
   endfunction

   function automatic bit char_fits(input logic [6:0] c, input int pos);
`ifdef OK_FRAME_RX_CASE_EN
      if (pos == 1) return (c == 7'h4B) || (c == 7'h6B);
`else
      if (pos == 1) return c == 7'h4B;
`endif
      if (pos == 2) return c == 7'h0D;
      return is_o(c);
   endfunction

   // Model: number of frame characters matched so far, idle cycles inside a partial frame,
   // pending event flag, and unbounded event totals (saturation applied when comparing).
   int m_prog = 0, m_idle = 0, m_ok = 0, m_err = 0;
   bit m_okv  = 1'b0;

   function automatic bit m_ready();
      return !(m_prog == 2 && m_okv && !i_ok_ack);
   endfunction

   always @(posedge i_clk or negedge i_rst_n) begin : model
      int np, ni, nok, nerr;
      bit nokv;
      if (!i_rst_n) begin
         m_prog <= 0; m_idle <= 0; m_ok <= 0; m_err <= 0; m_okv <= 1'b0;
      end else begin
         np = m_prog; ni = m_idle; nok = m_ok; nerr = m_err;
         nokv = i_ok_ack ? 1'b0 : m_okv;
         if (i_valid && m_ready()) begin
            ni = 0;
            if (char_fits(i_data, m_prog)) begin
               if (m_prog == 2) begin
                  np = 0; nok++; nokv = 1'b1;
               end else begin
                  np = m_prog + 1;
               end
            end else begin
               if (m_prog != 0) nerr++;
               np = is_o(i_data) ? 1 : 0;
            end
         end else if (m_prog != 0 && m_ready()) begin
            ni++;
            if (ni == TMO) begin
               np = 0; ni = 0; nerr++;
            end
         end
         m_prog <= np; m_idle <= ni; m_ok <= nok; m_err <= nerr; m_okv <= nokv;
      end
   end

   function automatic int sat(input int v, input int mx);
      return (v > mx) ? mx : v;
   endfunction

   always @(negedge i_clk) begin
      check("ready",      int'(o_ready),      int'(m_ready()));
      check("ok_valid",   int'(o_ok_valid),   int'(m_okv));
      check("state",      int'(o_state),      m_prog);
      check("ok_count",   int'(o_ok_count),   sat(m_ok, 255));
      check("err_count",  int'(o_err_count),  sat(m_err, 255));
      check("w2_ready",   int'(r2_ready),     int'(m_ready()));
      check("w2_ok_cnt",  int'(r2_ok_count),  sat(m_ok, 3));
      check("w2_err_cnt", int'(r2_err_count), sat(m_err, 3));
   end

   task automatic step(input int n);
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   task automatic send(input logic [6:0] c);
      bit got;
      i_valid = 1'b1;
      i_data  = c;
      for (int n = 0; n < 200; n++) begin
         @(negedge i_clk);
         got = o_ready;
         @(posedge i_clk);
         #1;
         if (got) begin
            i_valid = 1'b0;
            return;
         end
      end
      check("send_handshake_timeout", 0, 1);
      i_valid = 1'b0;
   endtask

   task automatic ack();
      i_ok_ack = 1'b1;
      step(1);
      i_ok_ack = 1'b0;
   endtask

   task automatic frame();
      send(7'h4F); send(7'h4B); send(7'h0D);
   endtask

   initial begin
      step(3);
      i_rst_n = 1'b1;
      step(1);

      // Reset mid-stream, with an event pending and a partial frame in flight
      frame();
      send(7'h4F); send(7'h4B);
      check("pre_reset_state", int'(o_state), 2);
      i_rst_n = 1'b0;
      step(3);
      check("rst_ok_valid", int'(o_ok_valid), 0);
      check("rst_ok_count", int'(o_ok_count), 0);
      check("rst_state",    int'(o_state), 0);
      i_rst_n = 1'b1;
      step(1);
      check("rst_ready", int'(o_ready), 1);

      // Clean frame
      send(7'h4F); send(7'h4B);
      send(7'h0D);
      check("clean_ok_valid", int'(o_ok_valid), 1);
      check("clean_ok_count", int'(o_ok_count), 1);
      check("clean_err",      int'(o_err_count), 0);
      ack();
      check("ack_clears", int'(o_ok_valid), 0);

      // Bad frame: 4F,41,4F,4B,0D
      send(7'h4F); send(7'h41); send(7'h4F); send(7'h4B); send(7'h0D);
      check("bad_err",   int'(o_err_count), 1);
      check("bad_ok",    int'(o_ok_count), 2);
      check("bad_state", int'(o_state), 0);
      ack();

      // Back-pressure longer than the timeout: stalled CR must not time out or be lost
      frame();
      send(7'h4F); send(7'h4B);
      i_valid = 1'b1;
      i_data  = 7'h0D;
      step(TMO + 6);
      check("bp_ready",  int'(o_ready), 0);
      check("bp_state",  int'(o_state), 2);
      check("bp_err",    int'(o_err_count), 1);
      i_ok_ack = 1'b1;
      step(1);
      i_ok_ack = 1'b0;
      i_valid  = 1'b0;
      check("bp_ok_count", int'(o_ok_count), 4);
      check("bp_set_wins", int'(o_ok_valid), 1);
      ack();
      check("bp_cleared", int'(o_ok_valid), 0);

      // Timeout exactly at the boundary
      send(7'h4F);
      step(TMO - 1);
      check("tmo_before", int'(o_state), 1);
      step(1);
      check("tmo_state", int'(o_state), 0);
      check("tmo_err",   int'(o_err_count), 2);
      send(7'h4F);
      step(TMO - 1);
      send(7'h4B);
      check("tmo_edge_state", int'(o_state), 2);
      check("tmo_edge_err",   int'(o_err_count), 2);
      send(7'h0D);
      check("tmo_edge_ok", int'(o_ok_count), 5);
      ack();

      // Saturation of the narrow instance
      for (int i = 0; i < 5; i++) begin
         frame();
         ack();
      end
      check("sat_w2_ok", int'(r2_ok_count), 3);
      check("sat_w8_ok", int'(o_ok_count), 10);

      // Lower-case characters
      send(7'h4F); send(7'h6B); send(7'h0D);
`ifdef OK_FRAME_RX_CASE_EN
      check("lc_k_ok",  int'(o_ok_count), 11);
      check("lc_k_err", int'(o_err_count), 2);
`else
      check("lc_k_ok",  int'(o_ok_count), 10);
      check("lc_k_err", int'(o_err_count), 3);
`endif
      ack();
      send(7'h6F); send(7'h6B); send(7'h0D);
`ifdef OK_FRAME_RX_CASE_EN
      check("lc_ok_ok",  int'(o_ok_count), 12);
      check("lc_ok_err", int'(o_err_count), 2);
`else
      check("lc_ok_ok",  int'(o_ok_count), 10);
      check("lc_ok_err", int'(o_err_count), 3);
`endif
      ack();
      step(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
